// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32i instruction fetch stage: PC, credit-limited IMEM requests, instruction buffer, redirect flush
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 3
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IMEM_Req_Valid,
    input  logic        IMEM_Req_Ready,
    output logic [31:0] IMEM_Req_Addr,
    input  logic        IMEM_Resp_Valid,
    input  logic [31:0] IMEM_Resp_Data,
    input  logic        Redirect_En,
    input  logic [31:0] Redirect_Target,
    output logic        IF_Valid,
    input  logic        ID_Ready,
    output logic [31:0] IF_Instr,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_PC4
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(BUF_DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(BUF_DEPTH - 1);

    logic [31:0]   r_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [31:0]   r_buf_instr [BUF_DEPTH];
    logic [31:0]   r_buf_pc    [BUF_DEPTH];

    logic [31:0]   w_target;
    logic [CW:0]   w_credits_used;
    logic          w_req_valid;
    logic          w_fire;
    logic          w_discard;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_head_nxt;
    logic [PW-1:0] w_tail_nxt;

    assign w_target       = Redirect_Target & ~32'h0000_0003;
    // Outstanding requests plus buffered entries may never exceed the buffer size.
    assign w_credits_used = {1'b0, r_inflight} + {1'b0, r_count};
    assign w_req_valid    = !RST && !Redirect_En && (w_credits_used < DEPTH_W);
    assign w_fire         = w_req_valid && IMEM_Req_Ready;
    assign w_discard      = (r_drop != '0) || Redirect_En;
    assign w_push         = IMEM_Resp_Valid && !w_discard;
    assign w_pop          = (r_count != '0) && ID_Ready && !Redirect_En;
    assign w_head_nxt     = (r_head == LAST_IDX) ? '0 : r_head + 1'b1;
    assign w_tail_nxt     = (r_tail == LAST_IDX) ? '0 : r_tail + 1'b1;

    assign IMEM_Req_Valid = w_req_valid;
    assign IMEM_Req_Addr  = r_pc;
    assign IF_Valid       = (r_count != '0);
    assign IF_Instr       = r_buf_instr[r_head];
    assign IF_PC          = r_buf_pc[r_head];
    assign IF_PC4         = IF_PC + 32'd4;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc       <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_inflight <= r_inflight + CW'(w_fire) - CW'(IMEM_Resp_Valid);
            if (Redirect_En) begin
                r_pc      <= w_target;
                r_resp_pc <= w_target;
                r_count   <= '0;
                r_head    <= '0;
                r_tail    <= '0;
                // A response landing in the redirect cycle is already discarded here.
                r_drop    <= r_inflight - CW'(IMEM_Resp_Valid);
            end else begin
                if (w_fire) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                    r_tail    <= w_tail_nxt;
                end
                if (w_pop) begin
                    r_head <= w_head_nxt;
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
                if (IMEM_Resp_Valid && (r_drop != '0)) begin
                    r_drop <= r_drop - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf_instr[i] <= '0;
                r_buf_pc[i]    <= '0;
            end
        end else if (w_push) begin
            r_buf_instr[r_tail] <= IMEM_Resp_Data;
            r_buf_pc[r_tail]    <= r_resp_pc;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32i pipeline. It owns the program counter, issues word fetches to instruction memory over a valid/ready request channel, and buffers returned instructions with their PCs. It presents them to the decode stage over a valid/ready handshake. Branch and jump redirects from execute flush all fetched-but-unconsumed work and restart fetch at the new target.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC of the first fetch after reset.
- BUF_DEPTH, 3: instruction buffer entries and total fetch credits. Minimum is 2. Must be 3 or more to sustain one instruction per cycle at IMEM latency 1.

Ports:
- CLK  in  1  clock; all state updates on its rising edge
- RST  in  1  reset, asynchronous, active-high
- IMEM_Req_Valid  out  1  fetch request valid
- IMEM_Req_Ready  in  1  IMEM accepts the request this cycle
- IMEM_Req_Addr  out  32  fetch address; always word aligned, equal to PC
- IMEM_Resp_Valid  in  1  response valid; responses return in order and cannot be back-pressured
- IMEM_Resp_Data  in  32  instruction word
- Redirect_En  in  1  taken branch or jump from execute
- Redirect_Target  in  32  new PC; bits [1:0] are ignored and forced to 0
- IF_Valid  out  1  instruction available to decode
- ID_Ready  in  1  decode accepts the instruction this cycle
- IF_Instr  out  32  instruction at the buffer head
- IF_PC  out  32  PC of IF_Instr
- IF_PC4  out  32  IF_PC + 4, modulo 2^32

## Operation
State:
- pc: next fetch address.
- resp_pc: PC of the next non-dropped response.
- inflight: requests accepted but not yet answered, range 0..BUF_DEPTH.
- drop: in-flight responses still to be discarded, never greater than inflight.
- buf: FIFO of {instr, pc} entries, count 0..BUF_DEPTH.

Rules:
- Issue:
  - IMEM_Req_Valid = !Redirect_En && (inflight + count < BUF_DEPTH).
  - This credit scheme guarantees buf never overflows.
  - A handshake (Valid && Ready) increments inflight and advances pc by 4. pc wraps modulo 2^32.
- Response:
  - Every IMEM_Resp_Valid decrements inflight.
  - If drop > 0 or Redirect_En is high, the response is discarded and drop decrements when it is above 0.
  - Otherwise {IMEM_Resp_Data, resp_pc} is pushed into buf and resp_pc advances by 4.
- Output:
  - IF_Valid = (count > 0); IF_Instr and IF_PC come from the buf head.
  - The head is popped when IF_Valid && ID_Ready && !Redirect_En.
  - Head contents are held stable while IF_Valid is high and ID_Ready is low.
- Redirect (highest priority):
  - pc and resp_pc are loaded with {Redirect_Target[31:2], 2'b00}.
  - buf is cleared.
  - drop is loaded with inflight, minus 1 if a response arrives in the same cycle.
  - IMEM_Req_Valid is forced low that cycle. Withdrawing a pending request on redirect is permitted by the IMEM contract.
- Simultaneous events:
  - A push and a pop in the same cycle leave count unchanged.
  - A request handshake and a response in the same cycle leave inflight unchanged.
  - A redirect overrides push, pop and issue.
- Reset: IMEM is reset by the same RST, so no responses arrive for pre-reset requests.

## Timing
Reset values, all applied asynchronously:
- pc and resp_pc = RESET_PC.
- inflight, drop and count = 0.
- IF_Valid = 0. IF_Instr = 0, IF_PC = 0 and IF_PC4 = 4.
- IMEM_Req_Valid goes high in the first cycle after RST deasserts.

Latency:
- IMEM responds at least 1 cycle after the request handshake.
- A response is registered into buf, so IF_Valid rises the cycle after the response. Minimum request-to-IF_Valid latency is 2 cycles.
- A redirect in cycle N produces a request to the target in cycle N+1.
- The first IF_Valid for the target is at N+3 or later.

Throughput:
- With IMEM latency 1, ID_Ready held high and BUF_DEPTH 3: one request and one instruction per cycle in steady state.
- Each extra cycle of IMEM latency needs one more credit to keep full rate.

Stalls:
- While IMEM_Req_Ready is low, IMEM_Req_Addr holds stable and pc does not advance.

## Test plan
- Reset: RESET_PC=32'h100, RST held 3 cycles -> IF_Valid=0 and IMEM_Req_Valid=0 during reset. The first request after release has address 32'h100.
- Streaming, latency 1, ID_Ready=1, memory returns address XOR 32'hA5A5_0000 -> requests 0x100, 0x104, 0x108... one per cycle. The first IF_Valid comes 2 cycles after the first handshake, then IF_PC/IF_Instr pairs arrive in order every cycle with IF_PC4 = IF_PC + 4.
- Back-pressure: ID_Ready=0 -> after 3 instructions are buffered, IMEM_Req_Valid stays low and the head holds stable. Releasing ID_Ready drains 0x100, 0x104, 0x108 in order with no loss or duplication.
- Redirect with 2 requests in flight, Redirect_Target=32'h2003 -> the next request address is 32'h2000. Both old responses are discarded, and the first IF_PC is 32'h2000.
- Redirect in the same cycle as a response arrival and an IF pop -> the response is discarded, the popped entry is not consumed and buf is empty next cycle. Only post-redirect instructions appear afterwards.
- IMEM_Req_Ready low for 5 cycles at pc 32'h10C -> IMEM_Req_Addr is 32'h10C throughout and the fetch sequence resumes at 32'h10C, 32'h110. Then PC wrap: a redirect to 32'hFFFF_FFFC -> the next fetch is 32'h0000_0000 and IF_PC4 = 0 for the instruction at 32'hFFFF_FFFC.
